grid_mem_arbiter: RTL and testbench
===================================

// Module: grid_mem_arbiter
// PURPOSE
//  Owns the single port of one 2-bit-per-cell game-grid RAM (my-board or enemy-board).
//  Arbitrates between the game FSM port (read/write) and the display port (read-only).
//  Provides a clear sequencer that writes EMPTY (2'b00) to every cell before a new game.
//  Sits between main_fsm/draw logic and the grid RAM; one instance per board.
// PARAMETERS
//  GRID_CELLS  100  number of valid cells, addresses 0..GRID_CELLS-1
//  RD_LAT      1    cycles from mem_addr driven to mem_rdata valid (RAM read latency)
//  STARVE_MAX  4    consecutive waiting cycles after which the display port wins
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous reset, active low
//  clr_req     in   1  pulse: start clearing the grid
//  clr_busy    out  1  clear sweep in progress
//  clr_done    out  1  one-cycle pulse: last cell written
//  fsm_req     in   1  FSM access request, level, held until fsm_gnt
//  fsm_we      in   1  1 = write, 0 = read
//  fsm_addr    in   8  cell address
//  fsm_wdata   in   2  write data
//  fsm_gnt     out  1  one-cycle grant pulse
//  fsm_rvalid  out  1  one-cycle pulse: fsm_rdata valid
//  fsm_rdata   out  2  read data
//  disp_req    in   1  display read request, level, held until disp_gnt
//  disp_addr   in   8  cell address
//  disp_gnt    out  1  one-cycle grant pulse
//  disp_rvalid out  1  one-cycle pulse: disp_rdata valid
//  disp_rdata  out  2  read data
//  mem_addr    out  8  RAM address
//  mem_wdata   out  2  RAM write data
//  mem_w_nr    out  1  RAM write enable (1 = write, 0 = read)
//  mem_rdata   in   2  RAM read data
// BEHAVIOUR
//  - Reset: every output 0; state IDLE; starvation counter 0; read-tag pipeline empty.
//  - All outputs registered. States: IDLE, CLEAR.
//  - IDLE, one decision per cycle, priority: clr_req > display starved > fsm_req > disp_req.
//  - Grant in cycle G: xx_gnt=1 and mem_addr/mem_w_nr/mem_wdata driven in the same cycle G.
//  - Starvation counter: +1 each cycle disp_req is high and not granted; saturates at
//    STARVE_MAX; cleared on disp_gnt. Counter==STARVE_MAX -> display wins over fsm_req.
//  - A requester granted in cycle G is not eligible in the decision made during G
//    (its req is still high that cycle); so each port gets at most one grant per 2 cycles.
//  - Reads: tag (fsm/disp) shifts through an RD_LAT+1 stage pipe; xx_rvalid=1 and
//    xx_rdata=mem_rdata (registered) in cycle G+RD_LAT+1. Writes produce no rvalid.
//  - fsm write with fsm_addr >= GRID_CELLS (incl. 8'hFF "no cords"): fsm_gnt pulses,
//    mem_w_nr stays 0 (write dropped). Out-of-range reads are granted, data undefined.
//  - clr_req in IDLE -> CLEAR next cycle; clr_busy=1; mem_w_nr=1, mem_wdata=2'b00,
//    mem_addr=0,1,..,GRID_CELLS-1, one cell per cycle; no grants while busy.
//  - Cycle addr==GRID_CELLS-1 written: clr_done=1 same cycle; next cycle IDLE,
//    clr_busy=0, mem_w_nr=0. Clear duration exactly GRID_CELLS cycles.
//  - clr_req while CLEAR: ignored. clr_req and fsm_req same cycle: clear wins, fsm_req
//    stays pending and is served after clear. Reads in flight at clear start still
//    deliver rvalid on schedule.
//  - Idle cycles (no grant, not clearing): mem_w_nr=0, mem_addr holds last value.
//  - rst_n low at any time (incl. mid-clear): immediate return to reset values; sweep
//    aborted; next clr_req restarts at address 0.
// TESTING
//  1. rst_n release, clr_req pulse -> clr_busy 100 cycles, mem_addr 0..99, mem_w_nr=1,
//     mem_wdata=00, clr_done with addr 99, then clr_busy=0, mem_w_nr=0.
//  2. fsm_req, we=1, addr 8'h23, wdata 01 -> fsm_gnt pulse, mem_addr 8'h23, w_nr=1, wdata 01.
//  3. RAM model holds 11 at 8'h05; fsm read 8'h05 -> fsm_rvalid 2 cycles after gnt,
//     fsm_rdata=11; disp_rvalid stays 0.
//  4. disp_req held high, fsm_req re-asserted after every gnt -> disp_gnt after at most
//     4 waiting cycles; counter returns to 0.
//  5. fsm write addr 8'hFF -> fsm_gnt pulse, mem_w_nr=0 throughout.
//  6. rst_n low during clear at addr 50 -> all outputs 0 at once; after release,
//     clr_req restarts sweep at addr 0; pending fsm_req during clear granted after clr_done.

Source files
------------

// File: rtl/grid_mem_arbiter.sv
// Single-port owner for one 2-bit-per-cell game grid RAM: arbitrates FSM and display
// accesses and runs a full-board clear sweep that writes EMPTY to every cell.
module grid_mem_arbiter #(
  parameter int GRID_CELLS = 100,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       clr_req_i,
  output logic       clr_busy_o,
  output logic       clr_done_o,
  input  logic       fsm_req_i,
  input  logic       fsm_we_i,
  input  logic [7:0] fsm_addr_i,
  input  logic [1:0] fsm_wdata_i,
  output logic       fsm_gnt_o,
  output logic       fsm_rvalid_o,
  output logic [1:0] fsm_rdata_o,
  input  logic       disp_req_i,
  input  logic [7:0] disp_addr_i,
  output logic       disp_gnt_o,
  output logic       disp_rvalid_o,
  output logic [1:0] disp_rdata_o,
  output logic [7:0] mem_addr_o,
  output logic [1:0] mem_wdata_o,
  output logic       mem_w_nr_o,
  input  logic [1:0] mem_rdata_i
);

  localparam int         TAG_W     = RD_LAT + 1;
  localparam int         SW        = $clog2(STARVE_MAX + 1);
  localparam logic [7:0] LAST_ADDR = 8'(GRID_CELLS - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e             state_q, state_d;
  logic [SW-1:0]      starve_q, starve_d;
  logic [TAG_W-1:0]   fsm_tag_q, fsm_tag_d, disp_tag_q, disp_tag_d;
  logic               fsm_gnt_q, fsm_gnt_d, disp_gnt_q, disp_gnt_d;
  logic               fsm_rvalid_q, fsm_rvalid_d, disp_rvalid_q, disp_rvalid_d;
  logic [1:0]         fsm_rdata_q, fsm_rdata_d, disp_rdata_q, disp_rdata_d;
  logic               clr_busy_q, clr_busy_d, clr_done_q, clr_done_d;
  logic [7:0]         mem_addr_q, mem_addr_d;
  logic [1:0]         mem_wdata_q, mem_wdata_d;
  logic               mem_w_nr_q, mem_w_nr_d;
  logic               grant_fsm, grant_disp;
  logic               fsm_elig, disp_elig, fsm_in_range;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_req_i) state_d = CLEAR;
      CLEAR:   if (mem_addr_q == LAST_ADDR) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A port shown granted this cycle still holds its req, so it sits out this decision.
  always_comb begin
    fsm_elig   = fsm_req_i && !fsm_gnt_q;
    disp_elig  = disp_req_i && !disp_gnt_q;
    grant_fsm  = 1'b0;
    grant_disp = 1'b0;
    if (state_q == IDLE && !clr_req_i) begin
      if (disp_elig && starve_q == SW'(STARVE_MAX)) grant_disp = 1'b1;
      else if (fsm_elig)                            grant_fsm  = 1'b1;
      else if (disp_elig)                           grant_disp = 1'b1;
    end
  end

  assign fsm_in_range = ({1'b0, fsm_addr_i} < 9'(GRID_CELLS));

  always_comb begin
    fsm_gnt_d   = grant_fsm;
    disp_gnt_d  = grant_disp;
    clr_busy_d  = 1'b0;
    clr_done_d  = 1'b0;
    mem_w_nr_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_d == CLEAR) begin
      clr_busy_d  = 1'b1;
      mem_w_nr_d  = 1'b1;
      mem_wdata_d = 2'b00;
      mem_addr_d  = (state_q == IDLE) ? 8'd0 : 8'(mem_addr_q + 8'd1);
      clr_done_d  = (mem_addr_d == LAST_ADDR);
    end else if (grant_fsm) begin
      mem_addr_d  = fsm_addr_i;
      mem_wdata_d = fsm_wdata_i;
      mem_w_nr_d  = fsm_we_i && fsm_in_range;
    end else if (grant_disp) begin
      mem_addr_d  = disp_addr_i;
    end
  end

  // Read tags ride alongside the RAM latency; the last stage captures mem_rdata.
  always_comb begin
    starve_d = starve_q;
    if (grant_disp)                                      starve_d = '0;
    else if (disp_elig && starve_q < SW'(STARVE_MAX))    starve_d = starve_q + SW'(1);
    fsm_tag_d     = TAG_W'({fsm_tag_q, grant_fsm && !fsm_we_i});
    disp_tag_d    = TAG_W'({disp_tag_q, grant_disp});
    fsm_rvalid_d  = fsm_tag_q[RD_LAT];
    disp_rvalid_d = disp_tag_q[RD_LAT];
    fsm_rdata_d   = fsm_tag_q[RD_LAT]  ? mem_rdata_i : fsm_rdata_q;
    disp_rdata_d  = disp_tag_q[RD_LAT] ? mem_rdata_i : disp_rdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_q      <= '0;
      fsm_tag_q     <= '0;
      disp_tag_q    <= '0;
      fsm_gnt_q     <= 1'b0;
      disp_gnt_q    <= 1'b0;
      fsm_rvalid_q  <= 1'b0;
      disp_rvalid_q <= 1'b0;
      fsm_rdata_q   <= 2'b00;
      disp_rdata_q  <= 2'b00;
      clr_busy_q    <= 1'b0;
      clr_done_q    <= 1'b0;
      mem_addr_q    <= 8'd0;
      mem_wdata_q   <= 2'b00;
      mem_w_nr_q    <= 1'b0;
    end else begin
      starve_q      <= starve_d;
      fsm_tag_q     <= fsm_tag_d;
      disp_tag_q    <= disp_tag_d;
      fsm_gnt_q     <= fsm_gnt_d;
      disp_gnt_q    <= disp_gnt_d;
      fsm_rvalid_q  <= fsm_rvalid_d;
      disp_rvalid_q <= disp_rvalid_d;
      fsm_rdata_q   <= fsm_rdata_d;
      disp_rdata_q  <= disp_rdata_d;
      clr_busy_q    <= clr_busy_d;
      clr_done_q    <= clr_done_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_w_nr_q    <= mem_w_nr_d;
    end
  end

  assign clr_busy_o    = clr_busy_q;
  assign clr_done_o    = clr_done_q;
  assign fsm_gnt_o     = fsm_gnt_q;
  assign fsm_rvalid_o  = fsm_rvalid_q;
  assign fsm_rdata_o   = fsm_rdata_q;
  assign disp_gnt_o    = disp_gnt_q;
  assign disp_rvalid_o = disp_rvalid_q;
  assign disp_rdata_o  = disp_rdata_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign mem_w_nr_o    = mem_w_nr_q;

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Bench for grid_mem_arbiter: RAM model, transaction-level reference model compared every
// cycle, and directed scenarios with literal expectations.
module tb_grid_mem_arbiter;

  localparam int GRID   = 100;
  localparam int RD_LAT = 1;
  localparam int STARVE = 4;

  logic       clk = 1'b0, rstN;
  logic       clrReq, fsmReq, fsmWe, dispReq;
  logic [7:0] fsmAddr, dispAddr;
  logic [1:0] fsmWdata;
  logic       clrBusy, clrDone, fsmGnt, fsmRvalid, dispGnt, dispRvalid, memWnr;
  logic [1:0] fsmRdata, dispRdata, memWdata;
  logic [1:0] memRdata = 2'b00;
  logic [7:0] memAddr;

  int checks = 0;
  int errors = 0;

  grid_mem_arbiter #(.GRID_CELLS(GRID), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE)) dut (
    .clk_i(clk), .rst_n_i(rstN), .clr_req_i(clrReq), .clr_busy_o(clrBusy), .clr_done_o(clrDone),
    .fsm_req_i(fsmReq), .fsm_we_i(fsmWe), .fsm_addr_i(fsmAddr), .fsm_wdata_i(fsmWdata),
    .fsm_gnt_o(fsmGnt), .fsm_rvalid_o(fsmRvalid), .fsm_rdata_o(fsmRdata),
    .disp_req_i(dispReq), .disp_addr_i(dispAddr), .disp_gnt_o(dispGnt),
    .disp_rvalid_o(dispRvalid), .disp_rdata_o(dispRdata),
    .mem_addr_o(memAddr), .mem_wdata_o(memWdata), .mem_w_nr_o(memWnr), .mem_rdata_i(memRdata)
  );

  always #5 clk = ~clk;

  logic [1:0] ram [256];
  logic [1:0] mram [256];

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]  = 2'(i % 4);
      mram[i] = 2'(i % 4);
    end
  end

  always @(posedge clk) begin
    if (memWnr) ram[memAddr] <= memWdata;
    memRdata <= ram[memAddr];
  end

  typedef struct { int due; bit isFsm; logic [1:0] data; } rd_t;
  rd_t pend[$];
  rd_t popped;
  int  cyc = 0, starve = 0, clearLeft = 0;
  bit  fOk, dOk, gf, gd;
  logic       eBusy = 0, eDone = 0, eFsmGnt = 0, eDispGnt = 0, eFsmRvalid = 0, eDispRvalid = 0, eWnr = 0;
  logic [1:0] eFsmRdata = 0, eDispRdata = 0, eWdata = 0;
  logic [7:0] eAddr = 0;

  // Reference model: decides each cycle from the arbitration rules and keeps reads as
  // timestamped transactions carrying the data the board held when they were granted.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cyc = 0; starve = 0; clearLeft = 0; pend.delete();
      eBusy = 0; eDone = 0; eFsmGnt = 0; eDispGnt = 0; eFsmRvalid = 0; eDispRvalid = 0;
      eWnr = 0; eFsmRdata = 0; eDispRdata = 0; eWdata = 0; eAddr = 0;
    end else begin
      cyc++;
      fOk = fsmReq && !eFsmGnt;
      dOk = dispReq && !eDispGnt;
      gf = 0; gd = 0;
      if (!eBusy) begin
        if (clrReq) clearLeft = GRID;
        else if (dOk && starve == STARVE) gd = 1;
        else if (fOk) gf = 1;
        else if (dOk) gd = 1;
      end
      if (gd) starve = 0;
      else if (dOk && starve < STARVE) starve++;
      eFsmRvalid = 0; eDispRvalid = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        popped = pend.pop_front();
        if (popped.isFsm) begin eFsmRvalid = 1; eFsmRdata = popped.data; end
        else begin eDispRvalid = 1; eDispRdata = popped.data; end
      end
      eFsmGnt = gf; eDispGnt = gd; eBusy = 0; eDone = 0; eWnr = 0;
      if (clearLeft > 0) begin
        eAddr = 8'(GRID - clearLeft);
        eWdata = 2'b00; eWnr = 1; eBusy = 1; eDone = (clearLeft == 1);
        mram[eAddr] = 2'b00;
        clearLeft--;
      end else if (gf) begin
        eAddr = fsmAddr; eWdata = fsmWdata;
        if (fsmWe) begin
          if (fsmAddr < GRID) begin eWnr = 1; mram[fsmAddr] = fsmWdata; end
        end else pend.push_back('{cyc + RD_LAT + 1, 1'b1, mram[fsmAddr]});
      end else if (gd) begin
        eAddr = dispAddr;
        pend.push_back('{cyc + RD_LAT + 1, 1'b0, mram[dispAddr]});
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("clr_busy", clrBusy, eBusy);
    checkOutput("clr_done", clrDone, eDone);
    checkOutput("fsm_gnt", fsmGnt, eFsmGnt);
    checkOutput("disp_gnt", dispGnt, eDispGnt);
    checkOutput("fsm_rvalid", fsmRvalid, eFsmRvalid);
    checkOutput("disp_rvalid", dispRvalid, eDispRvalid);
    checkOutput("fsm_rdata", fsmRdata, eFsmRdata);
    checkOutput("disp_rdata", dispRdata, eDispRdata);
    checkOutput("mem_addr", memAddr, eAddr);
    checkOutput("mem_wdata", memWdata, eWdata);
    checkOutput("mem_w_nr", memWnr, eWnr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic clr, input logic fReq, input logic fWe,
                               input logic [7:0] fAddr, input logic [1:0] fWdata,
                               input logic dReq, input logic [7:0] dAddr);
    clrReq = clr; fsmReq = fReq; fsmWe = fWe; fsmAddr = fAddr; fsmWdata = fWdata;
    dispReq = dReq; dispAddr = dAddr;
  endtask

  task automatic fsmAccess(input logic we, input logic [7:0] addr, input logic [1:0] wdata);
    bit got = 0;
    applyStimulus(0, 1, we, addr, wdata, 0, 8'h00);
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = fsmGnt;
    end
    fsmReq = 0;
    checkOutput("fsm_gnt arrives", got, 1);
  endtask

  int  busyCount, waitCnt;
  bit  got;

  initial begin
    rstN = 0;
    applyStimulus(0, 0, 0, 8'h00, 2'b00, 0, 8'h00);
    repeat (3) tick();
    checkOutput("reset clr_busy", clrBusy, 0);
    checkOutput("reset mem_addr", memAddr, 0);
    checkOutput("reset mem_w_nr", memWnr, 0);
    rstN = 1;
    tick();

    // Full sweep; a second clr_req mid-sweep must not stretch it.
    applyStimulus(1, 0, 0, 8'h00, 2'b00, 0, 8'h00);
    tick();
    clrReq = 0;
    busyCount = 0;
    for (int i = 0; i < 200 && clrBusy; i++) begin
      checkOutput("sweep addr", memAddr, i);
      checkOutput("sweep w_nr", memWnr, 1);
      checkOutput("sweep done", clrDone, (i == GRID - 1));
      clrReq = (i == 50);
      busyCount++;
      tick();
    end
    clrReq = 0;
    checkOutput("sweep length", busyCount, GRID);
    checkOutput("post sweep w_nr", memWnr, 0);
    checkOutput("post sweep addr hold", memAddr, GRID - 1);

    fsmAccess(1, 8'h23, 2'b01);
    checkOutput("wr23 addr", memAddr, 8'h23);
    checkOutput("wr23 w_nr", memWnr, 1);
    checkOutput("wr23 wdata", memWdata, 2'b01);
    tick();
    checkOutput("wr23 gnt is pulse", fsmGnt, 0);

    fsmAccess(1, 8'h05, 2'b11);
    tick();
    fsmAccess(0, 8'h05, 2'b00);
    checkOutput("rd05 w_nr", memWnr, 0);
    tick();
    checkOutput("rd05 rvalid early", fsmRvalid, 0);
    tick();
    checkOutput("rd05 rvalid", fsmRvalid, 1);
    checkOutput("rd05 rdata", fsmRdata, 2'b11);
    checkOutput("rd05 disp_rvalid", dispRvalid, 0);
    tick();

    // Display held against a constantly requesting FSM.
    applyStimulus(0, 1, 0, 8'h05, 2'b00, 1, 8'h23);
    waitCnt = 0; got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      waitCnt++;
      got = dispGnt;
    end
    applyStimulus(0, 0, 0, 8'h05, 2'b00, 0, 8'h23);
    checkOutput("disp granted", got, 1);
    checkOutput("disp wait bound", (waitCnt <= STARVE + 1), 1);
    checkOutput("disp addr", memAddr, 8'h23);
    repeat (2) tick();
    checkOutput("disp rvalid", dispRvalid, 1);
    checkOutput("disp rdata", dispRdata, 2'b01);

    fsmAccess(1, 8'hFF, 2'b10);
    checkOutput("wrFF w_nr", memWnr, 0);
    tick();
    fsmAccess(1, 8'd100, 2'b10);
    checkOutput("wr100 w_nr", memWnr, 0);
    tick();
    fsmAccess(1, 8'd99, 2'b10);
    checkOutput("wr99 w_nr", memWnr, 1);
    checkOutput("wr99 addr", memAddr, 8'd99);
    tick();

    // A read granted just before a clear still returns on schedule.
    fsmAccess(0, 8'h23, 2'b00);
    clrReq = 1;
    tick();
    clrReq = 0;
    checkOutput("inflight busy", clrBusy, 1);
    checkOutput("inflight early", fsmRvalid, 0);
    tick();
    checkOutput("inflight rvalid", fsmRvalid, 1);
    checkOutput("inflight rdata", fsmRdata, 2'b01);
    for (int i = 0; i < 200 && clrBusy; i++) tick();
    checkOutput("inflight sweep ends", clrBusy, 0);
    tick();

    // Reset mid-sweep, then clear and requests together.
    applyStimulus(1, 0, 0, 8'h00, 2'b00, 0, 8'h00);
    tick();
    clrReq = 0;
    for (int i = 0; i < 200 && memAddr != 8'd50; i++) tick();
    checkOutput("reached addr 50", memAddr, 50);
    rstN = 0;
    #1;
    checkOutput("abort busy", clrBusy, 0);
    checkOutput("abort addr", memAddr, 0);
    checkOutput("abort w_nr", memWnr, 0);
    checkOutput("abort done", clrDone, 0);
    repeat (2) tick();
    rstN = 1;
    tick();
    applyStimulus(1, 1, 1, 8'h10, 2'b10, 1, 8'h05);
    tick();
    clrReq = 0;
    checkOutput("restart addr", memAddr, 0);
    checkOutput("restart busy", clrBusy, 1);
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      got = fsmGnt || dispGnt;
    end
    checkOutput("starved disp first", dispGnt, 1);
    checkOutput("fsm waits", fsmGnt, 0);
    dispReq = 0;
    tick();
    checkOutput("pending fsm gnt", fsmGnt, 1);
    checkOutput("pending fsm addr", memAddr, 8'h10);
    checkOutput("pending fsm w_nr", memWnr, 1);
    fsmReq = 0;
    tick();
    checkOutput("post clear disp rvalid", dispRvalid, 1);
    checkOutput("post clear disp rdata", dispRdata, 2'b00);
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
